// File: rtl/fetch_collate_sched_pkg.sv
// Shared constants, types and per-WF state plane positions for the fetch scheduler.
package fetch_collate_sched_pkg;

  localparam int unsigned NUM_WF = 40;
  localparam int unsigned WFID_W = 6;

  // Per-WF state planes
  localparam int unsigned ST_OUT  = 0;
  localparam int unsigned ST_HALF = 1;
  localparam int unsigned ST_DISC = 2;
  localparam int unsigned ST_W    = 3;

  typedef logic [NUM_WF-1:0] wf_vec_t;
  typedef logic [WFID_W-1:0] wfid_t;

  typedef struct packed {
    wfid_t wfid;
    logic  second;
  } fetch_req_t;

  // Successor slot with explicit wrap at NUM_WF-1
  function automatic wfid_t wf_next(wfid_t id);
    return (id == WFID_W'(NUM_WF - 1)) ? '0 : id + WFID_W'(1);
  endfunction

endpackage

// File: rtl/fetch_collate_sched_if.sv
// Wavepool / fetch unit / collate signals seen by the fetch scheduler.
interface fetch_collate_sched_if;

  fetch_collate_sched_pkg::wf_vec_t wf_eligible;
  logic                             fetch_valid;
  logic                             fetch_ready;
  fetch_collate_sched_pkg::wfid_t   fetch_wfid;
  logic                             fetch_second;
  logic                             resp_valid;
  fetch_collate_sched_pkg::wfid_t   resp_wfid;
  logic                             resp_long;
  logic                             resp_discard;
  logic                             flush_valid;
  fetch_collate_sched_pkg::wfid_t   flush_wfid;
  fetch_collate_sched_pkg::wf_vec_t half_long;

  modport master (
    input  wf_eligible, fetch_ready, resp_valid, resp_wfid, resp_long,
           flush_valid, flush_wfid,
    output fetch_valid, fetch_wfid, fetch_second, resp_discard, half_long
  );

  modport slave (
    output wf_eligible, fetch_ready, resp_valid, resp_wfid, resp_long,
           flush_valid, flush_wfid,
    input  fetch_valid, fetch_wfid, fetch_second, resp_discard, half_long
  );

endinterface

// File: rtl/fetch_collate_sched_rr_pick.sv
// Round-robin first-set finder: lowest set bit of mask at or after start, wrapping at NUM-1.
module fetch_collate_sched_rr_pick
  import fetch_collate_sched_pkg::*;
#(
  parameter int unsigned NUM   = NUM_WF,
  parameter int unsigned IDX_W = WFID_W
) (
  input  logic [NUM-1:0]   mask_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      pos = {1'b0, start_i} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM)) pos = pos - (IDX_W+1)'(NUM);
      if (!found_o && mask_i[pos[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fetch_collate_sched.sv
// Per-wavefront fetch scheduler: one outstanding fetch per WF, round-robin issue,
// priority for the second dword of long instructions, flush/discard bookkeeping.
module fetch_collate_sched
  import fetch_collate_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fetch_collate_sched_if.master bus
);

  logic [ST_W-1:0][NUM_WF-1:0] st_q, st_d;
  wfid_t                       rr_ptr_q, rr_ptr_d;
  logic                        fv_q, fv_d;
  fetch_req_t                  req_q, req_d;

  wf_vec_t pri_mask, norm_mask;
  logic    pri_found, norm_found, win_found;
  wfid_t   pri_idx, norm_idx, win_idx, arb_ptr;
  wfid_t   rid, fid;
  logic    accept, can_arb, resp_live, flush_held, withdraw;

  assign rid        = bus.resp_wfid;
  assign fid        = bus.flush_wfid;
  assign accept     = fv_q & bus.fetch_ready;
  assign can_arb    = ~fv_q | accept;
  assign resp_live  = bus.resp_valid & st_q[ST_OUT][rid];
  assign flush_held = bus.flush_valid & fv_q & (req_q.wfid == fid);
  assign withdraw   = flush_held & ~bus.fetch_ready;

  // Scan starts just past the request retiring this cycle so back-to-back issue stays fair
  assign arb_ptr   = accept ? wf_next(req_q.wfid) : rr_ptr_q;
  assign pri_mask  = st_q[ST_HALF] & ~st_q[ST_OUT] & bus.wf_eligible;
  assign norm_mask = bus.wf_eligible & ~st_q[ST_OUT] & ~st_q[ST_HALF];

  fetch_collate_sched_rr_pick #(.NUM(NUM_WF), .IDX_W(WFID_W)) u_pick_pri (
    .mask_i  (pri_mask),
    .start_i (arb_ptr),
    .found_o (pri_found),
    .idx_o   (pri_idx)
  );

  fetch_collate_sched_rr_pick #(.NUM(NUM_WF), .IDX_W(WFID_W)) u_pick_norm (
    .mask_i  (norm_mask),
    .start_i (arb_ptr),
    .found_o (norm_found),
    .idx_o   (norm_idx)
  );

  assign win_found = pri_found | norm_found;
  assign win_idx   = pri_found ? pri_idx : norm_idx;

  always_comb begin
    st_d     = st_q;
    rr_ptr_d = rr_ptr_q;
    fv_d     = fv_q;
    req_d    = req_q;

    // Response retires the fetch, then completes or opens a long instruction
    if (resp_live) begin
      st_d[ST_OUT][rid] = 1'b0;
      if (st_q[ST_DISC][rid])      st_d[ST_DISC][rid] = 1'b0;
      else if (st_q[ST_HALF][rid]) st_d[ST_HALF][rid] = 1'b0;
      else if (bus.resp_long)      st_d[ST_HALF][rid] = 1'b1;
    end

    // Flush: withdraw an unaccepted held request, else mark an in-flight fetch for discard
    if (bus.flush_valid) begin
      st_d[ST_HALF][fid] = 1'b0;
      if (withdraw) begin
        fv_d              = 1'b0;
        st_d[ST_OUT][fid] = 1'b0;
      end else if (st_q[ST_OUT][fid] && !(resp_live && (rid == fid))) begin
        st_d[ST_DISC][fid] = 1'b1;
      end
    end

    if (accept) rr_ptr_d = arb_ptr;

    if (can_arb) begin
      if (win_found) begin
        fv_d                  = 1'b1;
        req_d.wfid            = win_idx;
        req_d.second          = st_q[ST_HALF][win_idx];
        st_d[ST_OUT][win_idx] = 1'b1;
      end else begin
        fv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q     <= '0;
      rr_ptr_q <= '0;
      fv_q     <= 1'b0;
      req_q    <= '0;
    end else begin
      st_q     <= st_d;
      rr_ptr_q <= rr_ptr_d;
      fv_q     <= fv_d;
      req_q    <= req_d;
    end
  end

  assign bus.fetch_valid  = fv_q;
  assign bus.fetch_wfid   = req_q.wfid;
  assign bus.fetch_second = req_q.second;
  assign bus.half_long    = st_q[ST_HALF];
  assign bus.resp_discard = rst & resp_live & st_q[ST_DISC][rid];

  // A returned dword must belong to a fetch this block has outstanding
  a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst)
    bus.resp_valid |-> st_q[ST_OUT][rid]);

endmodule

// File: tb/tb_fetch_collate_sched.sv
// Bench for fetch_collate_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_collate_sched;
  import fetch_collate_sched_pkg::*;

  localparam int NWF = int'(NUM_WF);

  logic clk;
  logic rst;
  fetch_collate_sched_if bus ();

  fetch_collate_sched dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;

  // Behavioural model state
  bit m_out[NWF];
  bit m_hl[NWF];
  bit m_disc[NWF];
  int m_ptr;
  bit m_fv;
  int m_wfid;
  bit m_second;
  int inflight[$];

  function automatic wf_vec_t wf_bit(int w);
    wf_vec_t v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic wf_vec_t model_hl_vec();
    wf_vec_t v;
    v = '0;
    for (int w = 0; w < NWF; w++) v[w] = m_hl[w];
    return v;
  endfunction

  function automatic bit model_discard();
    int r;
    r = int'(bus.resp_wfid);
    return rst && bus.resp_valid && (r < NWF) && m_out[r] && m_disc[r];
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit n_out[NWF];
    bit n_hl[NWF];
    bit n_disc[NWF];
    bit acc, resp_ok, n_fv, n_second;
    int r, f, start, win, w, n_ptr, n_wfid;
    if (!rst) begin
      for (int i = 0; i < NWF; i++) begin
        m_out[i] = 1'b0; m_hl[i] = 1'b0; m_disc[i] = 1'b0;
      end
      m_ptr = 0; m_fv = 1'b0; m_wfid = 0; m_second = 1'b0;
      inflight.delete();
      return;
    end
    n_out = m_out; n_hl = m_hl; n_disc = m_disc;
    n_fv = m_fv; n_wfid = m_wfid; n_second = m_second; n_ptr = m_ptr;
    acc = m_fv && bus.fetch_ready;
    r = int'(bus.resp_wfid);
    f = int'(bus.flush_wfid);
    resp_ok = bus.resp_valid && (r < NWF) && m_out[r];
    if (resp_ok) begin
      n_out[r] = 1'b0;
      if (m_disc[r])          n_disc[r] = 1'b0;
      else if (m_hl[r])       n_hl[r]   = 1'b0;
      else if (bus.resp_long) n_hl[r]   = 1'b1;
    end
    if (bus.flush_valid && (f < NWF)) begin
      n_hl[f] = 1'b0;
      if (m_fv && (m_wfid == f) && !bus.fetch_ready) begin
        n_fv = 1'b0;
        n_out[f] = 1'b0;
      end else if (m_out[f] && !(resp_ok && (r == f))) begin
        n_disc[f] = 1'b1;
      end
    end
    if (acc) begin
      inflight.push_back(m_wfid);
      n_ptr = (m_wfid + 1) % NWF;
    end
    if (!m_fv || acc) begin
      start = acc ? (m_wfid + 1) % NWF : m_ptr;
      win = -1;
      for (int pass = 0; pass < 2; pass++) begin
        for (int k = 0; k < NWF; k++) begin
          w = (start + k) % NWF;
          if (win < 0 && bus.wf_eligible[w] && !m_out[w] && (m_hl[w] == (pass == 0))) win = w;
        end
      end
      if (win >= 0) begin
        n_fv = 1'b1; n_wfid = win; n_second = m_hl[win]; n_out[win] = 1'b1;
      end else begin
        n_fv = 1'b0;
      end
    end
    m_out = n_out; m_hl = n_hl; m_disc = n_disc;
    m_fv = n_fv; m_wfid = n_wfid; m_second = n_second; m_ptr = n_ptr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wf_eligible = '0;
    bus.fetch_ready = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_wfid   = '0;
    bus.resp_long   = 1'b0;
    bus.flush_valid = 1'b0;
    bus.flush_wfid  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.resp_valid = 1'b1;
    bus.resp_wfid  = 6'd3;
    tick();
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_wfid !== '0 || bus.fetch_second !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: valid=%b wfid=%0d second=%b, required 0/0/0",
               bus.fetch_valid, bus.fetch_wfid, bus.fetch_second);
    end
    checks++;
    if (bus.half_long !== '0 || bus.resp_discard !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: half_long=%h discard=%b, required 0/0", bus.half_long, bus.resp_discard);
    end
    bus.resp_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single_issue();
    do_reset();
    bus.wf_eligible = wf_vec_t'(40'h1);
    bus.fetch_ready = 1'b1;
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== 6'd0 || bus.fetch_second !== 1'b0) begin
      errors++;
      $display("FAIL single_first: valid=%b wfid=%0d second=%b, required 1/0/0",
               bus.fetch_valid, bus.fetch_wfid, bus.fetch_second);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.fetch_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_no_reissue cycle %0d: valid=%b, required 0", i, bus.fetch_valid);
      end
    end
    bus.resp_valid = 1'b1;
    bus.resp_wfid  = 6'd0;
    tick();
    bus.resp_valid = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_resp_cycle: valid=%b, required 0", bus.fetch_valid);
    end
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== 6'd0) begin
      errors++;
      $display("FAIL single_reissue: valid=%b wfid=%0d, required 1/0", bus.fetch_valid, bus.fetch_wfid);
    end
  endtask

  task automatic test_rr_wrap();
    int exp_ord[4] = '{3, 7, 39, 3};
    do_reset();
    bus.wf_eligible = wf_bit(3) | wf_bit(7) | wf_bit(39);
    bus.fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== WFID_W'(exp_ord[k])) begin
        errors++;
        $display("FAIL rr_order[%0d]: valid=%b wfid=%0d, required 1/%0d",
                 k, bus.fetch_valid, bus.fetch_wfid, exp_ord[k]);
      end
      bus.resp_valid = (k > 0);
      bus.resp_wfid  = WFID_W'(exp_ord[(k > 0) ? k - 1 : 0]);
    end
    tick();
    bus.resp_valid = 1'b0;
  endtask

  task automatic test_long_priority();
    do_reset();
    bus.wf_eligible = wf_bit(5);
    bus.fetch_ready = 1'b1;
    tick();
    checks++;
    if (bus.fetch_wfid !== 6'd5 || bus.fetch_second !== 1'b0) begin
      errors++;
      $display("FAIL long_first: wfid=%0d second=%b, required 5/0", bus.fetch_wfid, bus.fetch_second);
    end
    tick();
    bus.resp_valid = 1'b1;
    bus.resp_wfid  = 6'd5;
    bus.resp_long  = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    checks++;
    if (bus.half_long !== wf_bit(5) || bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL long_half_set: half_long=%h valid=%b, required %h/0", bus.half_long, bus.fetch_valid, wf_bit(5));
    end
    bus.wf_eligible = wf_bit(2) | wf_bit(5) | wf_bit(9);
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== 6'd5 || bus.fetch_second !== 1'b1) begin
      errors++;
      $display("FAIL long_priority: valid=%b wfid=%0d second=%b, required 1/5/1",
               bus.fetch_valid, bus.fetch_wfid, bus.fetch_second);
    end
    tick();
    checks++;
    if (bus.fetch_wfid !== 6'd9 || bus.fetch_second !== 1'b0 || bus.half_long !== wf_bit(5)) begin
      errors++;
      $display("FAIL long_next_norm: wfid=%0d second=%b half_long=%h, required 9/0/%h",
               bus.fetch_wfid, bus.fetch_second, bus.half_long, wf_bit(5));
    end
    bus.resp_valid = 1'b1;
    bus.resp_wfid  = 6'd5;
    bus.resp_long  = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    bus.resp_long  = 1'b0;
    checks++;
    if (bus.half_long !== '0 || bus.fetch_wfid !== 6'd2) begin
      errors++;
      $display("FAIL long_complete: half_long=%h wfid=%0d, required 0/2", bus.half_long, bus.fetch_wfid);
    end
  endtask

  task automatic test_stall_withdraw();
    do_reset();
    bus.wf_eligible = wf_bit(12);
    tick();
    bus.wf_eligible = '0;
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== 6'd12) begin
      errors++;
      $display("FAIL stall_hold: valid=%b wfid=%0d, required 1/12", bus.fetch_valid, bus.fetch_wfid);
    end
    bus.flush_valid = 1'b1;
    bus.flush_wfid  = 6'd12;
    tick();
    bus.flush_valid = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_withdraw: valid=%b, required 0", bus.fetch_valid);
    end
    tick();
    bus.wf_eligible = wf_bit(12);
    bus.fetch_ready = 1'b1;
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== 6'd12) begin
      errors++;
      $display("FAIL stall_reissue: valid=%b wfid=%0d, required 1/12", bus.fetch_valid, bus.fetch_wfid);
    end
    tick();
    bus.resp_valid = 1'b1;
    bus.resp_wfid  = 6'd12;
    #1;
    checks++;
    if (bus.resp_discard !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_discard: discard=%b, required 0", bus.resp_discard);
    end
    tick();
    bus.resp_valid = 1'b0;
  endtask

  task automatic test_flush_discard();
    do_reset();
    bus.wf_eligible = wf_bit(4);
    bus.fetch_ready = 1'b1;
    tick();
    tick();
    bus.flush_valid = 1'b1;
    bus.flush_wfid  = 6'd4;
    tick();
    bus.flush_valid = 1'b0;
    bus.resp_valid  = 1'b1;
    bus.resp_wfid   = 6'd4;
    bus.resp_long   = 1'b1;
    #1;
    checks++;
    if (bus.resp_discard !== 1'b1) begin
      errors++;
      $display("FAIL flush_discard: discard=%b, required 1", bus.resp_discard);
    end
    tick();
    bus.resp_valid = 1'b0;
    bus.resp_long  = 1'b0;
    checks++;
    if (bus.half_long !== '0 || bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after_resp: half_long=%h valid=%b, required 0/0", bus.half_long, bus.fetch_valid);
    end
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== 6'd4) begin
      errors++;
      $display("FAIL flush_reeligible: valid=%b wfid=%0d, required 1/4", bus.fetch_valid, bus.fetch_wfid);
    end
    bus.flush_valid = 1'b1;
    bus.flush_wfid  = 6'd4;
    tick();
    bus.flush_valid = 1'b0;
    bus.resp_valid  = 1'b1;
    bus.resp_wfid   = 6'd4;
    #1;
    checks++;
    if (bus.resp_discard !== 1'b1) begin
      errors++;
      $display("FAIL flush_on_accept: discard=%b, required 1", bus.resp_discard);
    end
    tick();
    bus.resp_valid = 1'b0;
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_wfid !== 6'd4) begin
      errors++;
      $display("FAIL flush_accept_reissue: valid=%b wfid=%0d, required 1/4", bus.fetch_valid, bus.fetch_wfid);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    bus.wf_eligible = wf_bit(4);
    bus.fetch_ready = 1'b1;
    tick();
    tick();
    bus.resp_valid = 1'b1;
    bus.resp_wfid  = 6'd4;
    bus.resp_long  = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    bus.resp_long  = 1'b0;
    tick();
    checks++;
    if (bus.half_long !== wf_vec_t'(40'h10) || bus.fetch_valid !== 1'b1 || bus.fetch_second !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup: half_long=%h valid=%b second=%b, required 10/1/1",
               bus.half_long, bus.fetch_valid, bus.fetch_second);
    end
    rst = 1'b0;
    bus.resp_valid = 1'b1;
    bus.resp_wfid  = 6'd4;
    #1;
    checks++;
    if (bus.resp_discard !== 1'b0) begin
      errors++;
      $display("FAIL midrun_discard_forced: discard=%b, required 0", bus.resp_discard);
    end
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_wfid !== '0 || bus.fetch_second !== 1'b0 || bus.half_long !== '0) begin
      errors++;
      $display("FAIL midrun_reset: valid=%b wfid=%0d second=%b half_long=%h, required all 0",
               bus.fetch_valid, bus.fetch_wfid, bus.fetch_second, bus.half_long);
    end
    bus.resp_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_random();
    wf_vec_t e;
    int idx;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      e = wf_vec_t'({$urandom(), $urandom()});
      if ($urandom_range(1, 0) == 1) e = e & wf_vec_t'({$urandom(), $urandom()});
      bus.wf_eligible = e;
      bus.fetch_ready = ($urandom_range(3, 0) != 0);
      bus.resp_valid  = 1'b0;
      bus.resp_long   = ($urandom_range(1, 0) == 1);
      if (inflight.size() > 0 && $urandom_range(2, 0) != 0) begin
        idx = $urandom_range(inflight.size() - 1, 0);
        bus.resp_valid = 1'b1;
        bus.resp_wfid  = WFID_W'(inflight[idx]);
        inflight.delete(idx);
      end
      bus.flush_valid = ($urandom_range(11, 0) == 0);
      bus.flush_wfid  = WFID_W'($urandom_range(NWF - 1, 0));
      #1;
      checks++;
      if (bus.resp_discard !== model_discard()) begin
        errors++;
        $display("FAIL rand_discard cyc %0d: got %b, required %b", cyc, bus.resp_discard, model_discard());
      end
      tick();
      checks++;
      if (bus.fetch_valid !== m_fv || bus.fetch_wfid !== WFID_W'(m_wfid) || bus.fetch_second !== m_second) begin
        errors++;
        $display("FAIL rand_req cyc %0d: valid=%b wfid=%0d second=%b, required %b/%0d/%b",
                 cyc, bus.fetch_valid, bus.fetch_wfid, bus.fetch_second, m_fv, m_wfid, m_second);
      end
      checks++;
      if (bus.half_long !== model_hl_vec()) begin
        errors++;
        $display("FAIL rand_half_long cyc %0d: got %h, required %h", cyc, bus.half_long, model_hl_vec());
      end
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();
    test_reset();
    test_single_issue();
    test_rr_wrap();
    test_long_priority();
    test_stall_withdraw();
    test_flush_discard();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
